// File: rtl/csla_addsub_pipe.sv
// csla_addsub_pipe: two-stage carry-select adder/subtractor for the integer
// ALU path (ADD, SUB, SLT, SLTU) with valid/ready handshakes on both sides.
// Stage 1 forms the low-half sum and both speculative high-half sums; stage 2
// picks the high half using the low-half carry and produces result and flags.
module csla_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int HI_W = WIDTH - SPLIT;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  // Compare ops report a zero-extended single bit; flags stay on the raw sum.
  function automatic logic [WIDTH-1:0] select_result(
    input logic [1:0]       op_sel,
    input logic [WIDTH-1:0] sum,
    input logic             c,
    input logic             v,
    input logic             n
  );
    logic [WIDTH-1:0] res;
    case (op_sel)
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, n ^ v};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, ~c};
      default: res = sum;
    endcase
    return res;
  endfunction

  // Handshake control
  logic vld_p1;
  logic s2_free;
  logic accept;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_free;
  assign accept   = in_valid && in_ready;

  // ---- stage 0: operand prep and speculative half sums ----
  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [SPLIT:0]   lo_sum;
  logic [HI_W:0]    hi0_sum;
  logic [HI_W:0]    hi1_sum;
  logic             cprev0;
  logic             cprev1;

  // Low half plus both high-half candidates; carry into the MSB is recovered
  // from the MSB sum bit so no separate (WIDTH-1)-bit adder is needed.
  always_comb begin
    cin     = (op != OP_ADD);
    b_eff   = cin ? ~b : b;
    lo_sum  = {1'b0, a[SPLIT-1:0]} + {1'b0, b_eff[SPLIT-1:0]} + {{SPLIT{1'b0}}, cin};
    hi0_sum = {1'b0, a[WIDTH-1:SPLIT]} + {1'b0, b_eff[WIDTH-1:SPLIT]};
    hi1_sum = {1'b0, a[WIDTH-1:SPLIT]} + {1'b0, b_eff[WIDTH-1:SPLIT]} + {{HI_W{1'b0}}, 1'b1};
    cprev0  = hi0_sum[HI_W-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
    cprev1  = hi1_sum[HI_W-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
  end

  // ---- stage 1: registered half sums ----
  logic [1:0]      op_p1;
  logic [SPLIT-1:0] lo_p1;
  logic            lo_cout_p1;
  logic [HI_W-1:0] hi0_p1;
  logic [HI_W-1:0] hi1_p1;
  logic            cout0_p1;
  logic            cout1_p1;
  logic            cprev0_p1;
  logic            cprev1_p1;

  // Pipeline valid bits; the only state that must be cleared for correctness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_ready) vld_p1    <= in_valid;
      if (s2_free)  out_valid <= vld_p1;
    end
  end

  // Capture stage-1 data whenever a new operation is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1      <= op;
      lo_p1      <= lo_sum[SPLIT-1:0];
      lo_cout_p1 <= lo_sum[SPLIT];
      hi0_p1     <= hi0_sum[HI_W-1:0];
      hi1_p1     <= hi1_sum[HI_W-1:0];
      cout0_p1   <= hi0_sum[HI_W];
      cout1_p1   <= hi1_sum[HI_W];
      cprev0_p1  <= cprev0;
      cprev1_p1  <= cprev1;
    end
  end

  // ---- stage 2: carry select, flags and result ----
  logic [WIDTH-1:0] sel_sum;
  logic             sel_c;
  logic             sel_v;
  logic             sel_n;
  logic             sel_z;

  // The low-half carry picks which speculative high half is real.
  always_comb begin
    sel_sum = lo_cout_p1 ? {hi1_p1, lo_p1} : {hi0_p1, lo_p1};
    sel_c   = lo_cout_p1 ? cout1_p1 : cout0_p1;
    sel_v   = lo_cout_p1 ? (cout1_p1 ^ cprev1_p1) : (cout0_p1 ^ cprev0_p1);
    sel_n   = sel_sum[WIDTH-1];
    sel_z   = (sel_sum == '0);
  end

  // Output register only moves when stage 2 is free, so a stalled result holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      C      <= 1'b0;
      V      <= 1'b0;
      N      <= 1'b0;
      Z      <= 1'b0;
    end else if (s2_free && vld_p1) begin
      result <= select_result(op_p1, sel_sum, sel_c, sel_v, sel_n);
      C      <= sel_c;
      V      <= sel_v;
      N      <= sel_n;
      Z      <= sel_z;
    end
  end

endmodule

// File: tb/tb_csla_addsub_pipe.sv
// Bench for csla_addsub_pipe: directed ALU vectors, backpressure, random
// traffic against an arithmetic reference model, and reset while busy.
module tb_csla_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        C, V, N, Z;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [35:0] exp_q[$];

  logic [1:0]  d_op  [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
  logic [31:0] d_a   [11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'd5,
                              32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h80000000};
  logic [31:0] d_b   [11] = '{32'd1, 32'd1, 32'd1, 32'h00010000, 32'd5,
                              32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd1};
  // {result, C, V, N, Z}
  logic [35:0] d_exp [11] = '{{32'h80000000, 4'b0110}, {32'h00000000, 4'b1001},
                              {32'h00010000, 4'b0000}, {32'h00000000, 4'b1001},
                              {32'h00000000, 4'b1001}, {32'h7FFFFFFF, 4'b1100},
                              {32'hFFFFFFFF, 4'b0010}, {32'h00000001, 4'b1010},
                              {32'h00000000, 4'b1010}, {32'h00000001, 4'b0010},
                              {32'h00000001, 4'b1100}};
  logic [31:0] corner [7] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
                              32'hFFFFFFFF, 32'h0000FFFF, 32'h00010000};

  always #5 clk = ~clk;

  csla_addsub_pipe #(.WIDTH(32), .SPLIT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .C(C), .V(V), .N(N), .Z(Z)
  );

  // Reference: plain 33-bit two's-complement arithmetic and true comparisons.
  function automatic logic [35:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    logic [31:0] ye;
    logic [31:0] r;
    logic ci, c, v, n, z;
    ye = (o == 2'b00) ? y : ~y;
    ci = (o != 2'b00);
    s  = {1'b0, x} + {1'b0, ye} + 33'(ci);
    c  = s[32];
    n  = s[31];
    z  = (s[31:0] == 32'd0);
    v  = (x[31] == ye[31]) && (s[31] != x[31]);
    case (o)
      2'b10:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      2'b11:   r = (x < y) ? 32'd1 : 32'd0;
      default: r = s[31:0];
    endcase
    return {r, c, v, n, z};
  endfunction

  task automatic drive(input logic iv, input logic [1:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic ordy,
                       output logic acc, output logic xf, output logic ir,
                       output logic ov, output logic [35:0] obs);
    @(negedge clk);
    in_valid  = iv;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    #1;
    cyc++;
    ir  = in_ready;
    ov  = out_valid;
    acc = iv && in_ready;
    xf  = out_valid && ordy;
    obs = {result, C, V, N, Z};
    if (acc) exp_q.push_back(model(o, aa, bb));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if ({result, C, V, N, Z} !== 36'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {result, C, V, N, Z});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic acc, xf, ir, ov;
    logic [35:0] obs, m;
    int acc_cyc[$];
    int k = 0;
    for (int i = 0; i < 11 + 12 && k < 11; i++) begin
      if (i < 11) drive(1'b1, d_op[i], d_a[i], d_b[i], 1'b1, acc, xf, ir, ov, obs);
      else        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, acc, xf, ir, ov, obs);
      if (i < 11) begin
        n_checks++;
        if (!acc || !ir) begin
          n_fail++; $display("FAIL dir_accept[%0d]: got %b expected 1", i, acc);
        end
        acc_cyc.push_back(cyc);
      end
      if (xf && ov) begin
        m = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
        n_checks++;
        if (obs !== d_exp[k]) begin
          n_fail++; $display("FAIL dir_value[%0d]: got %h expected %h", k, obs, d_exp[k]);
        end
        n_checks++;
        if (obs !== m) begin
          n_fail++; $display("FAIL dir_model[%0d]: got %h expected %h", k, obs, m);
        end
        n_checks++;
        if (k < acc_cyc.size() && cyc != acc_cyc[k] + 2) begin
          n_fail++; $display("FAIL dir_latency[%0d]: got %0d cycles expected 2", k, cyc - acc_cyc[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 11) begin
      n_fail++; $display("FAIL dir_count: got %0d results expected 11", k);
    end
  endtask

  task automatic test_backpressure();
    logic acc, xf, ir, ov, ordy;
    logic [35:0] obs, m;
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      ordy = !(c >= 2 && c <= 5);
      drive(sent < 4, 2'b00, sent, 32'd1, ordy, acc, xf, ir, ov, obs);
      if (acc) sent++;
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (sent != 2 || ir !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready c%0d: got sent=%0d in_ready=%b expected 2,0", c, sent, ir);
        end
        n_checks++;
        if (ov !== 1'b1 || obs !== {32'd1, 4'b0000}) begin
          n_fail++; $display("FAIL bp_hold c%0d: got %b/%h expected 1/%h", c, ov, obs, {32'd1, 4'b0000});
        end
      end
      if (xf) begin
        m = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
        n_checks++;
        if (obs !== m || obs[35:4] !== 32'(got + 1) || c != 6 + got) begin
          n_fail++; $display("FAIL bp_out[%0d]: got %h at c%0d expected %h at c%0d", got, obs, c, m, 6 + got);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d results expected 4", got);
    end
  endtask

  task automatic test_random();
    logic acc, xf, ir, ov, ordy, iv, prev_stall;
    logic [35:0] obs, m, prev_obs;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    prev_stall = 1'b0;
    prev_obs   = '0;
    for (int c = 0; c < 460; c++) begin
      iv   = (c < 400) && ($urandom % 4 != 0);
      ordy = ($urandom % 10) < 7 || c >= 400;
      ro   = 2'($urandom % 4);
      ra   = ($urandom % 4 == 0) ? corner[$urandom % 7] : $urandom;
      rb   = ($urandom % 4 == 0) ? corner[$urandom % 7] : $urandom;
      drive(iv, ro, ra, rb, ordy, acc, xf, ir, ov, obs);
      if (prev_stall) begin
        n_checks++;
        if (ov !== 1'b1 || obs !== prev_obs) begin
          n_fail++; $display("FAIL rnd_stall_hold: got %b/%h expected 1/%h", ov, obs, prev_obs);
        end
      end
      if (xf) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_output: got %h expected none", obs);
        end else begin
          m = exp_q.pop_front();
          if (obs !== m) begin
            n_fail++; $display("FAIL rnd_value: got %h expected %h (acc=%b)", obs, m, acc);
          end
        end
      end
      prev_stall = ov && !ordy;
      prev_obs   = obs;
    end
    n_checks++;
    if (exp_q.size() != 0 || ir !== 1'b1) begin
      n_fail++; $display("FAIL rnd_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, xf, ir, ov;
    logic [35:0] obs;
    int acc_at;
    logic done;
    drive(1'b1, 2'b00, 32'd10, 32'd20, 1'b0, acc, xf, ir, ov, obs);
    drive(1'b1, 2'b00, 32'd30, 32'd40, 1'b0, acc, xf, ir, ov, obs);
    drive(1'b0, 2'b00, 32'd0,  32'd0,  1'b0, acc, xf, ir, ov, obs);
    n_checks++;
    if (ov !== 1'b1 || ir !== 1'b0) begin
      n_fail++; $display("FAIL mid_full: got ov=%b ir=%b expected 1,0", ov, ir);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || {result, C, V, N, Z} !== 36'd0) begin
      n_fail++; $display("FAIL mid_reset_async: got %b/%h expected 0/0", out_valid, {result, C, V, N, Z});
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, acc, xf, ir, ov, obs);
      n_checks++;
      if (ov !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale[%0d]: got out_valid %b expected 0", i, ov);
      end
    end
    drive(1'b1, 2'b01, 32'd100, 32'd1, 1'b1, acc, xf, ir, ov, obs);
    acc_at = cyc;
    n_checks++;
    if (!acc) begin
      n_fail++; $display("FAIL mid_accept: got %b expected 1", acc);
    end
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, acc, xf, ir, ov, obs);
      if (xf) begin
        done = 1'b1;
        n_checks++;
        if (obs !== {32'd99, 4'b1000} || cyc != acc_at + 2) begin
          n_fail++; $display("FAIL mid_after: got %h after %0d expected %h after 2", obs, cyc - acc_at, {32'd99, 4'b1000});
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++; $display("FAIL mid_timeout: got no result expected one within 8 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csla_addsub_pipe.md
Name: csla_addsub_pipe

Overview:
Two-stage pipelined 32-bit carry-select adder/subtractor for the integer ALU path (ADD, SUB, SLT, SLTU).
- Stage 1 computes the low-half sum and the two speculative high-half sums (carry-in 0 and 1), each with its carry-out and carry-into-MSB.
- Stage 2 selects the high half by the low-half carry and produces the result and C/V/N/Z flags.
- Valid/ready handshake on both sides; sustains one operation per cycle.

Parameters:
WIDTH, 32, operand/result width.
SPLIT, 16, low-half width; high half is WIDTH-SPLIT bits (1 <= SPLIT < WIDTH).

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  operation present on a, b, op.
in_ready  output  1  block accepts operation this cycle.
op  input  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  result/flags valid.
out_ready  input  1  consumer accepts result this cycle.
result  output  WIDTH  ADD/SUB sum, or zero-extended compare bit for SLT/SLTU.
C  output  1  carry-out of MSB (SUB/SLT/SLTU: 1 = no borrow).
V  output  1  signed overflow = carry-out(MSB) XOR carry-in(MSB).
N  output  1  MSB of arithmetic sum.
Z  output  1  arithmetic sum == 0.

Behaviour:
- Reset (async, any time, including mid-operation): s1_valid=0, out_valid=0, result=0, C=V=N=Z=0. All in-flight operations are discarded. in_ready=1 combinationally once reset deasserts.
- Operand prep: ADD uses b_eff=b, cin=0. SUB/SLT/SLTU use b_eff=~b, cin=1.
- Stage 1 (registered on accept):
  - lo = a[SPLIT-1:0] + b_eff[SPLIT-1:0] + cin, giving SPLIT bits plus lo_cout.
  - For k in {0,1}: hi_k = a[high] + b_eff[high] + k, giving the high bits, cout_k, and cprev_k (carry into bit WIDTH-1).
  - op is also registered.
- Stage 2 (registered on advance):
  - Select k = lo_cout. sum = {hi_k, lo}. C = cout_k. V = cout_k ^ cprev_k. N = sum[WIDTH-1]. Z = (sum == 0).
  - result: ADD/SUB -> sum. SLT -> {0..., N^V}. SLTU -> {0..., ~C}.
  - Flags always reflect the arithmetic sum, never the compare bit.
- Handshake:
  - s2_free = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_free.
  - Transfer in on in_valid & in_ready. Transfer out on out_valid & out_ready.
  - When s2_free: stage 2 loads stage 1 and out_valid <= s1_valid.
  - When stage 1 advances or is empty: it loads new input if accepted, else s1_valid <= 0.
  - Simultaneous accept, advance and output transfer in one cycle is legal. This gives full throughput.
- Latency: accept in cycle t -> out_valid in cycle t+2 with no backpressure.
- Stall: while out_valid & !out_ready, result/flags are held stable. Stage 1 holds one further op, so at most 2 ops are in flight. in_ready=0 while both stages are full and stalled.
- Ordering is strictly in-order; no op is dropped or duplicated.
- Values on a/b/op are ignored when in_valid=0. Output values are don't-care when out_valid=0 but must not change while out_valid=1 & !out_ready.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> after 2 cycles result=0x80000000, C=0, V=1, N=1, Z=0.
- ADD 0xFFFFFFFF + 0x00000001 -> result=0, C=1, V=0, N=0, Z=1. ADD 0x0000FFFF + 1 -> 0x00010000 (low carry selects hi_1 path).
- SUB 5 - 5 -> result=0, C=1, Z=1, V=0. SUB 0x80000000 - 1 -> 0x7FFFFFFF, V=1, N=0, C=1.
- SLT a=0xFFFFFFFF, b=1 -> result=1, N=1, V=0. SLTU same operands -> result=0, C=1. SLTU a=1, b=2 -> result=1, C=0.
- Backpressure: stream 4 ADDs (i + 1, i=0..3) back-to-back while out_ready=0 for cycles 2-5 -> in_ready drops after 2 ops accepted, output held at first result, then results 1,2,3,4 emerge in order with no gaps once out_ready=1.
- Assert rst for one cycle with 2 ops in flight -> out_valid=0 immediately, outputs zero, no stale results afterward. Next op accepted completes in 2 cycles.
